ahb_cmd_master: RTL and testbench

AHB-Lite single-transfer master that sits directly upstream of `sram_control` and drives its AHB slave port. It accepts commands (address, direction, write data) through a valid/ready handshake and buffers them in a small FIFO. Each command is issued as a pipelined NONSEQ transfer, where the address phase of transfer N overlaps the data phase of transfer N-1. Each completed transfer returns one response beat carrying read data and error status.

---
 rtl/ahb_pkg.sv | 28 ++
 rtl/ahb_cmd_fifo.sv | 71 +++++++
 rtl/ahb_cmd_master.sv | 118 +++++++++++
 tb/tb_ahb_cmd_master.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg
// Shared AHB-Lite definitions for the command master and its FIFO.
//   HTRANS_IDLE / HTRANS_NONSEQ : transfer-type encodings driven on HTRANS
//   HSIZE_WORD                  : the only transfer size this master issues
//   HRESP_OKAY / HRESP_ERROR    : slave response encodings on HRESP
//   ahb_cmd_t                   : one queued command {write, addr, wdata}
// The command struct has fixed field widths. The master's ADDR_W/DATA_W
// parameters must equal AHB_ADDR_W/AHB_DATA_W.
package ahb_pkg;

    localparam int AHB_ADDR_W = 32;
    localparam int AHB_DATA_W = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef struct packed {
        logic                  write;
        logic [AHB_ADDR_W-1:0] addr;
        logic [AHB_DATA_W-1:0] wdata;
    } ahb_cmd_t;

endpackage

// File: rtl/ahb_cmd_fifo.sv
// ahb_cmd_fifo
// Synchronous FIFO of ahb_cmd_t commands. Pointers and count are cleared by
// an asynchronous active-low reset. The storage array itself is not reset.
// There is no bypass: a full FIFO ignores push even when it also pops.
// Ports:
//   clk, rst_n : clock and async active-low reset
//   push       : write push_data when not full
//   push_data  : command to enqueue
//   pop        : drop the head entry when not empty
//   head       : oldest entry (meaningless while empty)
//   full       : DEPTH entries held
//   empty      : no entries held
module ahb_cmd_fifo
    import ahb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  ahb_cmd_t push_data,
    input  logic     pop,
    output ahb_cmd_t head,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    ahb_cmd_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master
// AHB-Lite single-transfer master. Commands enter through a valid/ready
// handshake into ahb_cmd_fifo. The FIFO head is driven as a NONSEQ address
// phase. On the accepting edge it moves into a data-phase register, so the
// address phase of one transfer overlaps the data phase of the previous one.
// Each completed data phase loads a response register that pulses rsp_valid
// for one cycle.
// Ports:
//   HCLK, HRESETn        : bus clock, async active-low reset
//   cmd_valid/cmd_ready  : command handshake (cmd_ready = FIFO not full)
//   cmd_write/addr/wdata : command contents
//   rsp_valid            : one-cycle pulse per completed transfer
//   rsp_write/rdata/err  : direction, read data (0 for writes), HRESP error
//   HADDR/HWRITE/HTRANS/HSIZE/HWDATA : AHB master outputs
//   HREADY/HRDATA/HRESP  : AHB slave returns
module ahb_cmd_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HRESP
);

    ahb_cmd_t          push_cmd;
    ahb_cmd_t          head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              nonseq;
    logic              idle_hold;
    logic              complete;

    logic              dp_valid;
    logic              dp_write;
    logic [DATA_W-1:0] dp_wdata;

    assign push_cmd  = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;

    ahb_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .push     (push),
        .push_data(push_cmd),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    // An IDLE address phase that was stretched by HREADY=0 stays IDLE until
    // HREADY releases. A command that arrives during the wait therefore
    // cannot change the address-phase signals mid-wait. A NONSEQ phase holds
    // by itself because the head cannot pop while HREADY is low.
    assign nonseq   = !empty && !idle_hold;
    assign HTRANS   = nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR    = nonseq ? head.addr : '0;
    assign HWRITE   = nonseq && head.write;
    assign HSIZE    = HSIZE_WORD;
    assign pop      = nonseq && HREADY;
    assign complete = dp_valid && HREADY;
    assign HWDATA   = (dp_valid && dp_write) ? dp_wdata : '0;

    // The data-phase and response registers advance only on HREADY edges.
    // A reset discards any in-flight transfer without producing a response.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            idle_hold <= 1'b0;
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_wdata  <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            idle_hold <= !HREADY && !nonseq;
            if (HREADY) begin
                dp_valid <= pop;
                if (pop) begin
                    dp_write <= head.write;
                    dp_wdata <= head.wdata;
                end
            end
            rsp_valid <= complete;
            if (complete) begin
                rsp_write <= dp_write;
                rsp_rdata <= dp_write ? '0 : HRDATA;
                rsp_err   <= (HRESP == HRESP_ERROR);
            end
        end
    end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// tb_ahb_cmd_master
// Bench for ahb_cmd_master. The reference model treats the FIFO as a queue
// of accepted commands, the data phase as at most one popped command, and a
// response as the completion of that command. Inputs are driven and outputs
// are sampled on the falling clock edge.
module tb_ahb_cmd_master;
    import ahb_pkg::*;

    localparam int DEPTH = 4;

    logic        HCLK;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;

    ahb_cmd_master #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .HADDR    (HADDR),
        .HWRITE   (HWRITE),
        .HTRANS   (HTRANS),
        .HSIZE    (HSIZE),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HRDATA   (HRDATA),
        .HRESP    (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    logic        drv_valid;
    logic        drv_write;
    logic [31:0] drv_addr;
    logic [31:0] drv_wdata;
    logic        drv_hready;
    logic [31:0] drv_hrdata;
    logic        drv_hresp;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ref_cmd_t;

    ref_cmd_t    ref_q[$];
    logic        ref_dp_valid;
    logic        ref_dp_write;
    logic [31:0] ref_dp_wdata;
    logic        exp_rsp_valid;
    logic        exp_rsp_write;
    logic [31:0] exp_rsp_rdata;
    logic        exp_rsp_err;
    logic        prev_hready;
    logic [1:0]  prev_htrans;
    logic [1:0]  exp_htrans;

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        ref_q.delete();
        ref_dp_valid  = 1'b0;
        ref_dp_write  = 1'b0;
        ref_dp_wdata  = '0;
        exp_rsp_valid = 1'b0;
        exp_rsp_write = 1'b0;
        exp_rsp_rdata = '0;
        exp_rsp_err   = 1'b0;
        prev_hready   = 1'b1;
        prev_htrans   = HTRANS_IDLE;
        exp_htrans    = HTRANS_IDLE;
    endtask

    // Compare every DUT output with what the model says this cycle shows.
    // After a wait-state edge, the address phase must repeat the last one.
    task automatic model_check();
        if (!prev_hready) exp_htrans = prev_htrans;
        else exp_htrans = (ref_q.size() > 0) ? HTRANS_NONSEQ : HTRANS_IDLE;
        check_output("cmd_ready", cmd_ready, ref_q.size() < DEPTH);
        check_output("htrans", HTRANS, exp_htrans);
        check_output("hsize", HSIZE, HSIZE_WORD);
        if (exp_htrans == HTRANS_NONSEQ && ref_q.size() > 0) begin
            check_output("haddr", HADDR, ref_q[0].addr);
            check_output("hwrite", HWRITE, ref_q[0].write);
        end else begin
            check_output("haddr_idle", HADDR, 0);
            check_output("hwrite_idle", HWRITE, 0);
        end
        check_output("hwdata", HWDATA, (ref_dp_valid && ref_dp_write) ? ref_dp_wdata : 32'h0);
        check_output("rsp_valid", rsp_valid, exp_rsp_valid);
        if (exp_rsp_valid) begin
            check_output("rsp_write", rsp_write, exp_rsp_write);
            check_output("rsp_rdata", rsp_rdata, exp_rsp_rdata);
            check_output("rsp_err", rsp_err, exp_rsp_err);
        end
    endtask

    // Drive this cycle's inputs and advance the model across the next edge.
    task automatic apply_stimulus();
        ref_cmd_t c;
        logic     push_ok;
        cmd_valid = drv_valid;
        cmd_write = drv_write;
        cmd_addr  = drv_addr;
        cmd_wdata = drv_wdata;
        HREADY    = drv_hready;
        HRDATA    = drv_hrdata;
        HRESP     = drv_hresp;

        push_ok = drv_valid && (ref_q.size() < DEPTH);
        exp_rsp_valid = ref_dp_valid && drv_hready;
        if (exp_rsp_valid) begin
            exp_rsp_write = ref_dp_write;
            exp_rsp_rdata = ref_dp_write ? 32'h0 : drv_hrdata;
            exp_rsp_err   = drv_hresp;
        end
        if (drv_hready) begin
            if (exp_htrans == HTRANS_NONSEQ && ref_q.size() > 0) begin
                c = ref_q.pop_front();
                ref_dp_valid = 1'b1;
                ref_dp_write = c.write;
                ref_dp_wdata = c.wdata;
            end else begin
                ref_dp_valid = 1'b0;
            end
        end
        if (push_ok) begin
            c.write = drv_write;
            c.addr  = drv_addr;
            c.wdata = drv_wdata;
            ref_q.push_back(c);
        end
        prev_hready = drv_hready;
        prev_htrans = exp_htrans;
    endtask

    task automatic tick();
        apply_stimulus();
        @(negedge HCLK);
        model_check();
    endtask

    task automatic set_cmd(input logic v, input logic w, input logic [31:0] a,
                           input logic [31:0] d);
        drv_valid = v;
        drv_write = w;
        drv_addr  = a;
        drv_wdata = d;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] wd [10];
        logic [31:0] hold_addr;
        logic [1:0]  hold_trans;
        logic [31:0] hold_wdata;
        logic        popping;
        logic        rose;

        HRESETn = 1'b0;
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        drv_hready = 1'b1;
        drv_hrdata = 32'h0;
        drv_hresp  = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        HREADY = 1'b1; HRDATA = '0; HRESP = 1'b0;
        model_reset();
        repeat (3) @(negedge HCLK);

        $display("[TB] reset values");
        check_output("rst_htrans", HTRANS, HTRANS_IDLE);
        check_output("rst_haddr", HADDR, 0);
        check_output("rst_hwrite", HWRITE, 0);
        check_output("rst_hwdata", HWDATA, 0);
        check_output("rst_hsize", HSIZE, 3'b010);
        check_output("rst_rsp_valid", rsp_valid, 0);
        check_output("rst_rsp_write", rsp_write, 0);
        check_output("rst_rsp_rdata", rsp_rdata, 0);
        check_output("rst_rsp_err", rsp_err, 0);
        HRESETn = 1'b1;
        model_check();

        $display("[TB] single write");
        set_cmd(1'b1, 1'b1, 32'h4, 32'hDEADBEEF);
        tick();
        check_output("t1_htrans", HTRANS, HTRANS_NONSEQ);
        check_output("t1_hwrite", HWRITE, 1);
        check_output("t1_haddr", HADDR, 32'h4);
        drv_valid = 1'b0;
        tick();
        check_output("t1_hwdata", HWDATA, 32'hDEADBEEF);
        drv_hrdata = 32'hFFFFFFFF;
        tick();
        check_output("t1_rsp_valid", rsp_valid, 1);
        check_output("t1_rsp_write", rsp_write, 1);
        check_output("t1_rsp_err", rsp_err, 0);
        check_output("t1_rsp_rdata", rsp_rdata, 0);
        drv_hrdata = 32'h0;
        tick();
        check_output("t1_rsp_pulse", rsp_valid, 0);

        $display("[TB] single read");
        set_cmd(1'b1, 1'b0, 32'h2, 32'h0);
        tick();
        drv_valid = 1'b0;
        tick();
        drv_hrdata = 32'h12345678;
        tick();
        check_output("t2_rsp_valid", rsp_valid, 1);
        check_output("t2_rsp_rdata", rsp_rdata, 32'h12345678);
        check_output("t2_rsp_write", rsp_write, 0);
        drv_hrdata = 32'h0;
        tick();

        $display("[TB] ten back-to-back writes");
        for (int t = 0; t < 13; t++) begin
            if (t < 10) begin
                wd[t] = $urandom;
                set_cmd(1'b1, 1'b1, 32'(t % 5), wd[t]);
            end else begin
                drv_valid = 1'b0;
            end
            tick();
            if (t < 10) begin
                check_output("t3_htrans", HTRANS, HTRANS_NONSEQ);
                check_output("t3_haddr", HADDR, 32'(t % 5));
            end
            if (t >= 1 && t <= 10) check_output("t3_hwdata", HWDATA, wd[t-1]);
            check_output("t3_rsp_valid", rsp_valid, (t >= 2 && t <= 11));
        end

        $display("[TB] wait states during second read");
        hold_addr = '0; hold_trans = '0; hold_wdata = '0;
        for (int t = 0; t < 9; t++) begin
            set_cmd(t < 3, 1'b0, 32'h100 + 32'(t * 4), 32'h0);
            drv_hready = !(t == 3 || t == 4);
            drv_hrdata = 32'hC0DE0000 | 32'(t);
            tick();
            if (t + 1 == 3) begin
                check_output("t4_haddr_c3", HADDR, 32'h108);
                hold_addr = HADDR; hold_trans = HTRANS; hold_wdata = HWDATA;
            end
            if (t + 1 == 4 || t + 1 == 5) begin
                check_output("t4_haddr_hold", HADDR, hold_addr);
                check_output("t4_htrans_hold", HTRANS, hold_trans);
                check_output("t4_hwdata_hold", HWDATA, hold_wdata);
            end
            check_output("t4_rsp_valid", rsp_valid, (t + 1 == 3 || t + 1 == 6 || t + 1 == 7));
            if (t + 1 == 3) check_output("t4_rdata1", rsp_rdata, 32'hC0DE0002);
            if (t + 1 == 6) check_output("t4_rdata2", rsp_rdata, 32'hC0DE0005);
            if (t + 1 == 7) check_output("t4_rdata3", rsp_rdata, 32'hC0DE0006);
        end
        drv_hready = 1'b1;
        drv_valid  = 1'b0;
        repeat (3) tick();

        $display("[TB] fill FIFO while HREADY low");
        drv_hready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            set_cmd(1'b1, t[0], 32'h200 + 32'(t * 4), $urandom);
            tick();
            check_output("t5_ready_fill", cmd_ready, (t < 3));
        end
        set_cmd(1'b1, 1'b0, 32'h210, 32'h0);
        tick();
        check_output("t5_ready_full", cmd_ready, 0);
        drv_hready = 1'b1;
        rose = 1'b0;
        for (int t = 0; t < 10 && !rose; t++) begin
            popping = (exp_htrans == HTRANS_NONSEQ) && drv_hready;
            tick();
            if (popping) begin
                check_output("t5_ready_after_pop", cmd_ready, 1);
                rose = 1'b1;
            end else begin
                check_output("t5_ready_wait", cmd_ready, 0);
            end
        end
        check_output("t5_pop_seen", rose, 1);
        tick();
        drv_valid = 1'b0;
        repeat (8) tick();

        $display("[TB] error response");
        set_cmd(1'b1, 1'b1, 32'h8, 32'h55AA55AA);
        tick();
        set_cmd(1'b1, 1'b0, 32'hC, 32'h0);
        tick();
        drv_valid = 1'b0;
        drv_hresp = 1'b1;
        tick();
        check_output("t6_err_valid", rsp_valid, 1);
        check_output("t6_err_write", rsp_write, 1);
        check_output("t6_err_flag", rsp_err, 1);
        drv_hresp  = 1'b0;
        drv_hrdata = 32'hBEEF0001;
        tick();
        check_output("t6_next_valid", rsp_valid, 1);
        check_output("t6_next_write", rsp_write, 0);
        check_output("t6_next_err", rsp_err, 0);
        check_output("t6_next_rdata", rsp_rdata, 32'hBEEF0001);
        drv_hrdata = 32'h0;
        tick();

        $display("[TB] reset during data phase");
        set_cmd(1'b1, 1'b1, 32'h30, 32'h11111111);
        tick();
        set_cmd(1'b1, 1'b1, 32'h34, 32'h22222222);
        tick();
        check_output("t7_hwdata_pre", HWDATA, 32'h11111111);
        drv_valid = 1'b0;
        cmd_valid = 1'b0;
        #2 HRESETn = 1'b0;
        #1;
        check_output("t7_htrans_rst", HTRANS, HTRANS_IDLE);
        check_output("t7_hwdata_rst", HWDATA, 0);
        check_output("t7_haddr_rst", HADDR, 0);
        check_output("t7_rsp_rst", rsp_valid, 0);
        model_reset();
        repeat (2) begin
            @(negedge HCLK);
            check_output("t7_rsp_in_rst", rsp_valid, 0);
        end
        HRESETn = 1'b1;
        model_check();
        check_output("t7_ready_release", cmd_ready, 1);
        set_cmd(1'b1, 1'b0, 32'h40, 32'h0);
        tick();
        check_output("t7_first_push", HTRANS, HTRANS_NONSEQ);
        check_output("t7_first_addr", HADDR, 32'h40);
        drv_valid = 1'b0;
        repeat (4) tick();

        $display("[TB] randomized traffic");
        for (int t = 0; t < 400; t++) begin
            set_cmd($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), $urandom, $urandom);
            drv_hready = $urandom_range(0, 9) < 7;
            drv_hresp  = $urandom_range(0, 7) == 0;
            drv_hrdata = $urandom;
            tick();
        end
        drv_valid  = 1'b0;
        drv_hready = 1'b1;
        drv_hresp  = 1'b0;
        repeat (12) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
